// File: rtl/multi_debouncer.sv
// Multi-channel debouncer with symmetric saturating filters and optional
// auto-repeat. A single sample counter is shared by all channels. Each channel
// is one instance of multi_debouncer_ch in an instance array.

// Filter and auto-repeat logic for one channel
module multi_debouncer_ch #(
  parameter int SAT_MAX    = 150,
  parameter bit REPEAT_EN  = 1'b0,
  parameter int REP_DELAY  = 100,
  parameter int REP_PERIOD = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic debounced,
  output logic pressed,
  output logic released,
  output logic repeat_pulse
);
  localparam int SW = $clog2(SAT_MAX + 1);
  localparam logic [SW-1:0] SAT_LAST = SW'(SAT_MAX - 1);

  logic [SW-1:0] sat_cnt;
  logic          flip, rise, fall;

  // Level flips on the Nth consecutive disagreeing tick
  assign flip = tick && (raw != debounced) && (sat_cnt == SAT_LAST);
  assign rise = flip && raw;
  assign fall = flip && !raw;

  // Saturating filter: count disagreeing ticks, restart on any agreeing tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt   <= '0;
      debounced <= 1'b0;
      pressed   <= 1'b0;
      released  <= 1'b0;
    end else begin
      pressed  <= rise;
      released <= fall;
      if (tick) begin
        if (raw == debounced || flip) sat_cnt <= '0;
        else                          sat_cnt <= sat_cnt + 1'b1;
        if (flip) debounced <= raw;
      end
    end
  end

  if (REPEAT_EN) begin : g_rep
    localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} rep_state_t;

    rep_state_t    state, nxt_state;
    logic [RW-1:0] rep_cnt, nxt_cnt;
    logic          rep_fire;

    // State register; the repeat pulse is registered like pressed/released
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state        <= IDLE;
        rep_cnt      <= '0;
        repeat_pulse <= 1'b0;
      end else begin
        state        <= nxt_state;
        rep_cnt      <= nxt_cnt;
        repeat_pulse <= rep_fire;
      end
    end

    // Next state: a release always wins and returns to IDLE
    always_comb begin
      nxt_state = state;
      nxt_cnt   = rep_cnt;
      if (fall) begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end else begin
        case (state)
          IDLE: if (rise) begin
            nxt_state = DELAY;
            nxt_cnt   = '0;
          end
          DELAY: if (tick) begin
            if (rep_cnt == DLY_LAST) begin
              nxt_state = REPEAT;
              nxt_cnt   = '0;
            end else nxt_cnt = rep_cnt + 1'b1;
          end
          REPEAT: if (tick) begin
            if (rep_cnt == PER_LAST) nxt_cnt = '0;
            else                     nxt_cnt = rep_cnt + 1'b1;
          end
          default: begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
          end
        endcase
      end
    end

    // Output: fire when the active interval expires on a tick (not on release)
    always_comb begin
      rep_fire = 1'b0;
      if (tick && !fall) begin
        if (state == DELAY  && rep_cnt == DLY_LAST) rep_fire = 1'b1;
        if (state == REPEAT && rep_cnt == PER_LAST) rep_fire = 1'b1;
      end
    end
  end else begin : g_norep
    assign repeat_pulse = 1'b0;
  end
endmodule

// Top level: shared sample tick plus one filter instance per channel
module multi_debouncer #(
  parameter int width                  = 1,
  parameter int sampling_pulse_period  = 25000,
  parameter int saturating_counter_max = 150,
  parameter bit repeat_enable          = 1'b0,
  parameter int repeat_delay           = 100,
  parameter int repeat_period          = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] glitchy_signal,
  output logic [width-1:0] debounced_signal,
  output logic [width-1:0] pressed,
  output logic [width-1:0] released,
  output logic [width-1:0] repeat_pulse
);
  localparam int CW = $clog2(sampling_pulse_period);
  localparam logic [CW-1:0] SMP_LAST = CW'(sampling_pulse_period - 1);

  logic [CW-1:0] smp_cnt;
  logic          tick;

  assign tick = (smp_cnt == SMP_LAST);

  // Free-running sample counter, wraps after the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    smp_cnt <= '0;
    else if (tick) smp_cnt <= '0;
    else           smp_cnt <= smp_cnt + 1'b1;
  end

  multi_debouncer_ch #(
    .SAT_MAX   (saturating_counter_max),
    .REPEAT_EN (repeat_enable),
    .REP_DELAY (repeat_delay),
    .REP_PERIOD(repeat_period)
  ) u_ch [width-1:0] (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .raw         (glitchy_signal),
    .debounced   (debounced_signal),
    .pressed     (pressed),
    .released    (released),
    .repeat_pulse(repeat_pulse)
  );
endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios followed by random toggling,
// every cycle compared against a tick-level behavioural model.
module tb_multi_debouncer;
  localparam int W = 2, SP = 4, SM = 3, RD = 4, RP = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sig = '0;
  logic [W-1:0] deb, prs, rel, rep;

  int total = 0;
  int bad   = 0;

  multi_debouncer #(
    .width(W), .sampling_pulse_period(SP), .saturating_counter_max(SM),
    .repeat_enable(1'b1), .repeat_delay(RD), .repeat_period(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .glitchy_signal(sig),
    .debounced_signal(deb), .pressed(prs), .released(rel), .repeat_pulse(rep)
  );

  always #5 clk = ~clk;

  // Model: edges since reset release, per-channel level, run of disagreeing
  // ticks, and ticks held since the press tick (-1 when not held)
  int           ecount;
  logic [W-1:0] m_lvl, m_pr, m_rl, m_rp;
  int           dis  [W];
  int           held [W];

  task automatic model_reset();
    ecount = 0; m_lvl = '0; m_pr = '0; m_rl = '0; m_rp = '0;
    for (int i = 0; i < W; i++) begin dis[i] = 0; held[i] = -1; end
  endtask

  task automatic model_edge();
    bit tk;
    tk = (ecount % SP) == SP - 1;
    ecount++;
    m_pr = '0; m_rl = '0; m_rp = '0;
    if (tk) begin
      for (int i = 0; i < W; i++) begin
        if (sig[i] != m_lvl[i]) begin
          dis[i]++;
          if (dis[i] == SM) begin
            m_lvl[i] = sig[i];
            dis[i]   = 0;
            if (sig[i]) begin m_pr[i] = 1'b1; held[i] = 0; end
            else        begin m_rl[i] = 1'b1; held[i] = -1; end
          end
        end else dis[i] = 0;
        if (m_lvl[i] && !m_pr[i]) begin
          held[i]++;
          if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0)) m_rp[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("debounced", 32'(deb), 32'(m_lvl));
    check("pressed",   32'(prs), 32'(m_pr));
    check("released",  32'(rel), 32'(m_rl));
    check("repeat",    32'(rep), 32'(m_rp));
  endtask

  task automatic step(input logic [W-1:0] v);
    sig = v;
    @(posedge clk);
    if (rst_n) model_edge();
    #1 check_all();
  endtask

  // Assert reset between edges, toggle inputs while held, release
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    for (int k = 0; k < n; k++) step(W'($urandom));
    rst_n = 1'b1;
    model_reset();
  endtask

  int rp_seen;

  initial begin
    #1;
    do_reset(6);

    // Glitch: high across ticks 3 and 7 only
    for (int k = 0; k < 8; k++) step(2'b01);
    for (int k = 0; k < 8; k++) step(2'b00);
    check("glitch_deb", 32'(deb), 32'h0);

    // Press from cycle 0: level and pulse on tick 11
    do_reset(2);
    for (int k = 0; k < 11; k++) step(2'b01);
    check("press_early", 32'(deb), 32'h0);
    step(2'b01);
    check("press_t11_deb", 32'(deb), 32'h1);
    check("press_t11_pulse", 32'(prs), 32'h1);
    step(2'b01);
    check("press_1cyc", 32'(prs), 32'h0);

    // Hold: repeat pulses at edges 27, 35, 43
    rp_seen = 0;
    for (int k = 0; k < 31; k++) begin
      step(2'b01);
      if (rep[0]) rp_seen++;
      if (ecount - 1 == 27) check("rep_first", 32'(rep), 32'h1);
    end
    check("rep_count", 32'(rp_seen), 32'd3);

    // Release over three ticks: falls on edge 55
    for (int k = 0; k < 12; k++) step(2'b00);
    check("rel_t55_deb", 32'(deb), 32'h0);
    check("rel_t55_pulse", 32'(rel), 32'h1);
    step(2'b00);
    check("rel_1cyc", 32'(rel), 32'h0);
    for (int k = 0; k < 12; k++) step(2'b00);
    check("rep_stopped", 32'(rep), 32'h0);

    // Independence: ch1 starts one tick after ch0
    for (int k = 0; k < 4; k++) step(2'b01);
    for (int k = 0; k < 24; k++) step(2'b11);
    check("indep_both", 32'(deb), 32'h3);
    for (int k = 0; k < 16; k++) step(2'b00);

    // Reset mid-count discards progress
    for (int k = 0; k < 6; k++) step(2'b01);
    do_reset(3);
    for (int k = 0; k < 11; k++) step(2'b01);
    check("rst_mid_deb", 32'(deb), 32'h0);
    step(2'b01);
    check("rst_mid_press", 32'(prs), 32'h1);

    // Random toggling with long runs, one reset in the middle
    for (int k = 0; k < 1600; k++) begin
      if (k == 800) do_reset(2);
      step(sig ^ {W'($urandom_range(23) == 0), 1'($urandom_range(23) == 0)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
